// File: rtl/lzc_arbiter.sv
// Round-robin arbiter that shares one leading-zero counter between NREQ framed requesters.
// Define LZC_ARB_TIMEOUT_EN to add a WAIT watchdog and the sticky timeout_err output.
module lzc_arbiter #(
  parameter int NREQ    = 4,
  parameter int IDW     = 2,
  parameter int WIDTH   = 32,
  parameter int WORD    = 8,
  parameter int TIMEOUT = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ-1:0]       req_mode,
  input  logic [NREQ*WIDTH-1:0] req_data,
  output logic [NREQ-1:0]       req_ready,
  output logic                  lzc_mode,
  output logic                  lzc_ivalid,
  output logic [WIDTH-1:0]      lzc_data,
  input  logic                  lzc_ovalid,
  input  logic [8:0]            lzc_zeros,
  output logic                  res_valid,
  output logic [IDW-1:0]        res_id,
  output logic [8:0]            res_zeros,
  output logic                  busy
`ifdef LZC_ARB_TIMEOUT_EN
  ,
  output logic                  timeout_err
`endif
);

  localparam int BW = (WORD > 1) ? $clog2(WORD) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(WORD - 1);

  typedef enum logic [1:0] {IDLE, SEND, WAIT} state_t;

  state_t           state, state_next;
  logic [IDW-1:0]   ptr, gid, grant_id;
  logic             grant_found;
  logic [BW-1:0]    beat_cnt;
  logic [WIDTH-1:0] req_word [NREQ];
  logic             xfer, last_beat, timed_out, frame_done;

  function automatic logic [IDW-1:0] wrap_add(input logic [IDW-1:0] base, input int offs);
    int s;
    s = int'(base) + offs;
    if (s >= NREQ) s = s - NREQ;
    return IDW'(s);
  endfunction

  for (genvar n = 0; n < NREQ; n++) begin : g_unpack
    assign req_word[n] = req_data[n*WIDTH +: WIDTH];
  end

  // First valid requester at or after the pointer, wrapping around
  always_comb begin
    grant_found = 1'b0;
    grant_id    = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (!grant_found && req_valid[wrap_add(ptr, i)]) begin
        grant_found = 1'b1;
        grant_id    = wrap_add(ptr, i);
      end
    end
  end

  assign xfer      = (state == SEND) && req_valid[gid];
  assign last_beat = (beat_cnt == LAST_BEAT);
  assign busy      = (state != IDLE);

  always_comb begin
    req_ready = '0;
    if (state == SEND) req_ready[gid] = 1'b1;
  end

`ifdef LZC_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] wait_cnt;

  assign timed_out = (state == WAIT) && !lzc_ovalid && (wait_cnt == TW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt    <= '0;
      timeout_err <= 1'b0;
    end else begin
      wait_cnt <= (state == WAIT && !frame_done) ? wait_cnt + 1'b1 : '0;
      if (timed_out) timeout_err <= 1'b1;
    end
  end
`else
  // Never fires for any legal TIMEOUT; WAIT blocks until the LZC answers
  assign timed_out = (TIMEOUT < 0);
`endif

  assign frame_done = (state == WAIT) && (lzc_ovalid || timed_out);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (grant_found) state_next = SEND;
      SEND:    if (xfer && last_beat) state_next = WAIT;
      WAIT:    if (frame_done) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Grant bookkeeping, LZC drive and the registered result strobe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr        <= '0;
      gid        <= '0;
      beat_cnt   <= '0;
      lzc_mode   <= 1'b0;
      lzc_ivalid <= 1'b0;
      lzc_data   <= '0;
      res_valid  <= 1'b0;
      res_id     <= '0;
      res_zeros  <= '0;
    end else begin
      res_valid  <= 1'b0;
      lzc_ivalid <= xfer;
      if (state == IDLE && grant_found) begin
        gid      <= grant_id;
        ptr      <= wrap_add(grant_id, 1);
        beat_cnt <= '0;
      end
      if (xfer) begin
        lzc_data <= req_word[gid];
        if (beat_cnt == '0) lzc_mode <= req_mode[gid];
        beat_cnt <= last_beat ? '0 : beat_cnt + 1'b1;
      end
      if (frame_done) begin
        res_valid <= 1'b1;
        res_id    <= gid;
        res_zeros <= timed_out ? 9'h1FF : lzc_zeros;
      end
    end
  end

endmodule

// File: tb/tb_lzc_arbiter.sv
// Directed self-checking bench for lzc_arbiter with a small behavioural LZC stand-in.
module tb_lzc_arbiter;
  localparam int NREQ = 4, IDW = 2, WIDTH = 32, WORD = 8, TIMEOUT = 64;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic [NREQ-1:0]       req_valid = '0;
  logic [NREQ-1:0]       req_mode = '0;
  logic [NREQ*WIDTH-1:0] req_data = '0;
  logic [NREQ-1:0]       req_ready;
  logic                  lzc_mode, lzc_ivalid, lzc_ovalid;
  logic [WIDTH-1:0]      lzc_data;
  logic [8:0]            lzc_zeros;
  logic                  res_valid, busy;
  logic [IDW-1:0]        res_id;
  logic [8:0]            res_zeros;
  logic                  model_ovalid, stray_ovalid = 1'b0, model_mute = 1'b0;
  logic [8:0]            model_zeros;
`ifdef LZC_ARB_TIMEOUT_EN
  logic                  timeout_err;
`endif

  int assert_cnt = 0, fail_cnt = 0;

  always #5 clk = ~clk;

  assign lzc_ovalid = model_ovalid | stray_ovalid;
  assign lzc_zeros  = model_zeros;

  lzc_arbiter #(.NREQ(NREQ), .IDW(IDW), .WIDTH(WIDTH), .WORD(WORD), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_mode(req_mode), .req_data(req_data),
    .req_ready(req_ready), .lzc_mode(lzc_mode), .lzc_ivalid(lzc_ivalid), .lzc_data(lzc_data),
    .lzc_ovalid(lzc_ovalid), .lzc_zeros(lzc_zeros), .res_valid(res_valid), .res_id(res_id),
    .res_zeros(res_zeros), .busy(busy)
`ifdef LZC_ARB_TIMEOUT_EN
    , .timeout_err(timeout_err)
`endif
  );

  function automatic logic [8:0] countLz(input logic [WIDTH*WORD-1:0] v);
    int n = 0;
    for (int i = WIDTH*WORD-1; i >= 0; i--) begin
      if (v[i]) break;
      n++;
    end
    return 9'(n);
  endfunction

  function automatic int ohIndex(input logic [NREQ-1:0] v);
    for (int i = 0; i < NREQ; i++) if (v[i]) return i;
    return -1;
  endfunction

  // LZC stand-in: one result the cycle after the last beat of a frame arrives
  logic [WIDTH*WORD-1:0] model_buf;
  int model_beats;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      model_ovalid <= 1'b0;
      model_zeros  <= '0;
      model_beats  <= 0;
      model_buf    <= '0;
    end else begin
      model_ovalid <= 1'b0;
      if (lzc_ivalid) begin
        model_buf <= {model_buf[WIDTH*WORD-WIDTH-1:0], lzc_data};
        if (model_beats == WORD-1) begin
          model_beats <= 0;
          if (!model_mute) begin
            model_ovalid <= 1'b1;
            model_zeros  <= countLz({model_buf[WIDTH*WORD-WIDTH-1:0], lzc_data});
          end
        end else begin
          model_beats <= model_beats + 1;
        end
      end
    end
  end

  // Observation logs: beats, bubbles, per-frame mode, grants and results
  int ivalid_total = 0, bubble_total = 0, mode_err = 0, ready_err = 0;
  int res_cnt = 0, grant_cnt = 0, mode_cnt = 0, mon_beats = 0, mon_gap = 0;
  logic mon_mode = 1'b0;
  logic [NREQ-1:0] prev_ready = '0;
  logic [IDW-1:0] res_id_log [64];
  logic [8:0] res_zero_log [64];
  logic mode_log [64];
  int grant_log [64];

  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mon_beats  <= 0;
      mon_gap    <= 0;
      prev_ready <= '0;
    end else begin
      if (lzc_ivalid) begin
        ivalid_total <= ivalid_total + 1;
        if (mon_beats == 0) begin
          mon_mode <= lzc_mode;
          if (mode_cnt < 64) mode_log[mode_cnt] <= lzc_mode;
          mode_cnt <= mode_cnt + 1;
        end else begin
          bubble_total <= bubble_total + mon_gap;
          if (lzc_mode != mon_mode) mode_err <= mode_err + 1;
        end
        mon_gap   <= 0;
        mon_beats <= (mon_beats == WORD-1) ? 0 : mon_beats + 1;
      end else if (mon_beats != 0) begin
        mon_gap <= mon_gap + 1;
      end
      if (res_valid) begin
        if (res_cnt < 64) begin
          res_id_log[res_cnt]   <= res_id;
          res_zero_log[res_cnt] <= res_zeros;
        end
        res_cnt <= res_cnt + 1;
      end
      if (req_ready != '0 && req_ready != prev_ready) begin
        if (grant_cnt < 64) grant_log[grant_cnt] <= ohIndex(req_ready);
        grant_cnt <= grant_cnt + 1;
        if (prev_ready != '0) ready_err <= ready_err + 1;
      end
      if (req_ready != '0 && !$onehot(req_ready)) ready_err <= ready_err + 1;
      prev_ready <= req_ready;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assert_cnt++;
    if (observed !== expected) begin
      fail_cnt++;
      $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Drives nframes frames from one requester; optional stall or mid-frame reset
  task automatic applyStimulus(input int id, input logic [31:0] first_data, input logic [31:0] rest_data,
                               input logic mode, input int nframes, input int stall_after,
                               input int stall_len, input int reset_at);
    int beats = 0, frame = 0, budget = 2000;
    logic xf;
    req_mode[id] = mode;
    req_data[id*WIDTH +: WIDTH] = first_data;
    req_valid[id] = 1'b1;
    while (frame < nframes && budget > 0) begin
      @(negedge clk);
      xf = req_ready[id] & req_valid[id];
      @(posedge clk);
      #1;
      budget--;
      if (xf) begin
        beats++;
        if (reset_at > 0 && beats == reset_at) begin
          rst_n = 1'b0;
          req_valid[id] = 1'b0;
          return;
        end
        if (beats == WORD) begin
          frame++;
          beats = 0;
          req_data[id*WIDTH +: WIDTH] = first_data;
          if (frame == nframes) req_valid[id] = 1'b0;
        end else begin
          req_data[id*WIDTH +: WIDTH] = rest_data;
        end
        if (stall_len > 0 && beats == stall_after) begin
          req_valid[id] = 1'b0;
          repeat (stall_len) @(posedge clk);
          #1;
          req_valid[id] = 1'b1;
        end
      end
    end
    checkOutput($sformatf("frames_sent_req%0d", id), frame, nframes);
  endtask

  task automatic waitResults(input int target);
    int budget = 300;
    while (res_cnt < target && budget > 0) begin
      @(posedge clk);
      #1;
      budget--;
    end
    repeat (5) @(posedge clk);
    #1;
    checkOutput("result_count", res_cnt, target);
  endtask

  task automatic resetDut();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int r0, iv0, b0, g0, m0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    $display("[TB] idle after reset");
    repeat (10) begin
      @(negedge clk);
      checkOutput("idle_status", {busy, req_ready, lzc_ivalid, res_valid}, 32'h0);
    end
    checkOutput("reset_lzc_data", lzc_data, 32'h0);
    checkOutput("reset_res", {lzc_mode, res_id, res_zeros}, 32'h0);

    $display("[TB] single frame from requester 2");
    @(posedge clk);
    #1;
    r0 = res_cnt; iv0 = ivalid_total; b0 = bubble_total; m0 = mode_cnt;
    applyStimulus(2, 32'h0000_0000, 32'h00F0_0000, 1'b0, 1, 0, 0, 0);
    waitResults(r0 + 1);
    checkOutput("r2_beats", ivalid_total - iv0, 8);
    checkOutput("r2_bubbles", bubble_total - b0, 0);
    checkOutput("r2_id", res_id_log[r0], 2);
    checkOutput("r2_zeros", res_zero_log[r0], 40);
    checkOutput("r2_mode", mode_log[m0], 0);
    checkOutput("r2_busy_after", busy, 0);

    $display("[TB] all requesters contending");
    resetDut();
    r0 = res_cnt; g0 = grant_cnt; m0 = mode_cnt;
    fork
      applyStimulus(0, 32'h8000_0000, 32'h8000_0000, 1'b0, 2, 0, 0, 0);
      applyStimulus(1, 32'h4000_0000, 32'h4000_0000, 1'b1, 1, 0, 0, 0);
      applyStimulus(2, 32'h2000_0000, 32'h2000_0000, 1'b0, 1, 0, 0, 0);
      applyStimulus(3, 32'h1000_0000, 32'h1000_0000, 1'b1, 1, 0, 0, 0);
    join
    waitResults(r0 + 5);
    for (int k = 0; k < 5; k++) begin
      checkOutput($sformatf("rr_grant%0d", k), grant_log[g0+k], k % 4);
      checkOutput($sformatf("rr_res_id%0d", k), res_id_log[r0+k], k % 4);
      checkOutput($sformatf("rr_zeros%0d", k), res_zero_log[r0+k], k % 4);
      checkOutput($sformatf("rr_mode%0d", k), mode_log[m0+k], k % 2);
    end
    checkOutput("mode_constant", mode_err, 0);
    checkOutput("ready_onehot", ready_err, 0);

    $display("[TB] requester 1 stalls mid-frame");
    r0 = res_cnt; iv0 = ivalid_total; b0 = bubble_total;
    applyStimulus(1, 32'h0000_FFFF, 32'h0000_FFFF, 1'b0, 1, 5, 3, 0);
    waitResults(r0 + 1);
    checkOutput("stall_beats", ivalid_total - iv0, 8);
    checkOutput("stall_bubbles", bubble_total - b0, 3);
    checkOutput("stall_id", res_id_log[r0], 1);
    checkOutput("stall_zeros", res_zero_log[r0], 16);

    $display("[TB] stray ovalid in idle and send");
    r0 = res_cnt;
    stray_ovalid = 1'b1;
    @(posedge clk);
    #1;
    stray_ovalid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    checkOutput("stray_idle", res_cnt - r0, 0);
    fork
      applyStimulus(3, 32'h0000_0000, 32'h0FFF_FFFF, 1'b0, 1, 0, 0, 0);
      begin
        repeat (4) @(posedge clk);
        #1;
        checkOutput("stray_in_send", {busy, req_ready}, 5'h18);
        stray_ovalid = 1'b1;
        @(posedge clk);
        #1;
        stray_ovalid = 1'b0;
      end
    join
    waitResults(r0 + 1);
    checkOutput("stray_send_id", res_id_log[r0], 3);
    checkOutput("stray_send_zeros", res_zero_log[r0], 36);

    $display("[TB] reset in the middle of a frame");
    applyStimulus(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1, 0, 0, 5);
    #1;
    checkOutput("midreset_ctrl", {busy, req_ready, lzc_ivalid, lzc_mode, res_valid}, 32'h0);
    checkOutput("midreset_data", lzc_data, 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    r0 = res_cnt; iv0 = ivalid_total;
    applyStimulus(2, 32'h0000_0001, 32'h0000_0001, 1'b0, 1, 0, 0, 0);
    waitResults(r0 + 1);
    checkOutput("post_reset_beats", ivalid_total - iv0, 8);
    checkOutput("post_reset_id", res_id_log[r0], 2);
    checkOutput("post_reset_zeros", res_zero_log[r0], 31);

`ifdef LZC_ARB_TIMEOUT_EN
    $display("[TB] silent LZC triggers timeout");
    checkOutput("timeout_err_clear", timeout_err, 0);
    model_mute = 1'b1;
    r0 = res_cnt;
    applyStimulus(1, 32'h0000_0001, 32'h0000_0001, 1'b0, 1, 0, 0, 0);
    waitResults(r0 + 1);
    checkOutput("timeout_id", res_id_log[r0], 1);
    checkOutput("timeout_zeros", res_zero_log[r0], 9'h1FF);
    checkOutput("timeout_err_set", timeout_err, 1);
    checkOutput("timeout_idle", busy, 0);
    model_mute = 1'b0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: observed no end of test, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
